// File: rtl/pipememarb.sv
// Single-port memory sequencer/arbiter shared by the IF and MEM pipeline stages.
// Grants one access at a time (data over fetch), counts a fixed latency, returns a done pulse.
module pipememarb #(
  parameter int LAT = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic [31:0] irdata,
  output logic        idone,
  output logic        istall,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        ddone,
  output logic        dstall,
  output logic [31:0] maddr,
  output logic        mwe,
  output logic [31:0] mwdata,
  output logic        mreq,
  input  logic [31:0] mrdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester raises ireq/dreq and holds it (with address/data stable)
  // until its one-cycle done pulse; the done cycle is the only cycle its stall is low.
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] maddr_q, maddr_d;
  logic        mwe_q, mwe_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic        mreq_q, mreq_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        idone_q, idone_d;
  logic        ddone_q, ddone_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    mwe_d    = 1'b0;
    mreq_d   = 1'b0;
    idone_d  = 1'b0;
    ddone_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq) begin
          state_d  = DBUSY;
          maddr_d  = daddr;
          mwe_d    = dwe;
          mwdata_d = dwdata;
          mreq_d   = 1'b1;
          cnt_d    = LAT_M1;
        end else if (ireq) begin
          state_d = IBUSY;
          maddr_d = iaddr;
          mreq_d  = 1'b1;
          cnt_d   = LAT_M1;
        end
      end
      IBUSY, DBUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (state_q == IBUSY) begin
            irdata_d = mrdata;
            idone_d  = 1'b1;
          end else begin
            drdata_d = mrdata;
            ddone_d  = 1'b1;
          end
        end
      end
      // Requests still visible here belong to the access just completed.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      maddr_q  <= 32'd0;
      mwe_q    <= 1'b0;
      mwdata_q <= 32'd0;
      mreq_q   <= 1'b0;
      irdata_q <= 32'd0;
      drdata_q <= 32'd0;
      idone_q  <= 1'b0;
      ddone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      maddr_q  <= maddr_d;
      mwe_q    <= mwe_d;
      mwdata_q <= mwdata_d;
      mreq_q   <= mreq_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      idone_q  <= idone_d;
      ddone_q  <= ddone_d;
    end
  end

  assign maddr     = maddr_q;
  assign mwe       = mwe_q;
  assign mwdata    = mwdata_q;
  assign mreq      = mreq_q;
  assign irdata    = irdata_q;
  assign drdata    = drdata_q;
  assign idone     = idone_q;
  assign ddone     = ddone_q;
  assign istall    = ireq & ~idone_q;
  assign dstall    = dreq & ~ddone_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipememarb.sv
// Bench for pipememarb: three builds (LAT=2, 1, 3) share one stimulus set; each
// scenario task checks the build it targets. Cycle k starts 1ns after the k-th edge.
module tb_pipememarb;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ireq = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dreq = 1'b0;
  logic        dwe = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic [31:0] mrdata = '0;

  logic [31:0] irdata2, drdata2, maddr2, mwdata2;
  logic        idone2, istall2, ddone2, dstall2, mwe2, mreq2;
  logic [1:0]  st2;
  logic [31:0] irdata1, drdata1, maddr1, mwdata1;
  logic        idone1, istall1, ddone1, dstall1, mwe1, mreq1;
  logic [1:0]  st1;
  logic [31:0] irdata3, drdata3, maddr3, mwdata3;
  logic        idone3, istall3, ddone3, dstall3, mwe3, mreq3;
  logic [1:0]  st3;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  localparam logic [1:0] S_IDLE = 2'd0;

  pipememarb #(.LAT(2)) u2 (
    .clock(clock), .resetn(resetn), .ireq(ireq), .iaddr(iaddr), .irdata(irdata2),
    .idone(idone2), .istall(istall2), .dreq(dreq), .dwe(dwe), .daddr(daddr),
    .dwdata(dwdata), .drdata(drdata2), .ddone(ddone2), .dstall(dstall2),
    .maddr(maddr2), .mwe(mwe2), .mwdata(mwdata2), .mreq(mreq2), .mrdata(mrdata),
    .dbg_state(st2));

  pipememarb #(.LAT(1)) u1 (
    .clock(clock), .resetn(resetn), .ireq(ireq), .iaddr(iaddr), .irdata(irdata1),
    .idone(idone1), .istall(istall1), .dreq(dreq), .dwe(dwe), .daddr(daddr),
    .dwdata(dwdata), .drdata(drdata1), .ddone(ddone1), .dstall(dstall1),
    .maddr(maddr1), .mwe(mwe1), .mwdata(mwdata1), .mreq(mreq1), .mrdata(mrdata),
    .dbg_state(st1));

  pipememarb #(.LAT(3)) u3 (
    .clock(clock), .resetn(resetn), .ireq(ireq), .iaddr(iaddr), .irdata(irdata3),
    .idone(idone3), .istall(istall3), .dreq(dreq), .dwe(dwe), .daddr(daddr),
    .dwdata(dwdata), .drdata(drdata3), .ddone(ddone3), .dstall(dstall3),
    .maddr(maddr3), .mwe(mwe3), .mwdata(mwdata3), .mreq(mreq3), .mrdata(mrdata),
    .dbg_state(st3));

  // clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    iaddr = '0; daddr = '0; dwdata = '0; mrdata = '0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic pop_exp(output logic [31:0] v);
    if (exp_q.size() == 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL scoreboard_underflow: got empty queue, required an entry");
      v = 'x;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    do_reset();
    resetn = 1'b0;
    ireq = 1'b1;
    #1;
    vec_cnt++;
    if ({maddr2, mwe2, mwdata2, mreq2, irdata2, drdata2, idone2, ddone2, st2} !== '0) begin
      err_cnt++; $display("FAIL reset_regs: got nonzero registered outputs, required 0");
    end
    vec_cnt++;
    if (istall2 !== 1'b1) begin
      err_cnt++; $display("FAIL reset_istall: got %b required 1", istall2);
    end
    do_reset();
    step();  // cycle 0
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h100; dwdata = 32'h0BADF00D;
    step();  // cycle 1: store issued
    #2;
    vec_cnt++;
    if (mreq2 !== 1'b1 || mwe2 !== 1'b1) begin
      err_cnt++; $display("FAIL reset_pre_issue: got mreq=%b mwe=%b required 1 1", mreq2, mwe2);
    end
    resetn = 1'b0;
    #1;
    vec_cnt++;
    if (mreq2 !== 1'b0 || mwe2 !== 1'b0 || ddone2 !== 1'b0 || maddr2 !== 32'h0 || st2 !== S_IDLE) begin
      err_cnt++;
      $display("FAIL reset_async: got mreq=%b mwe=%b ddone=%b maddr=%h st=%0d required all 0",
               mreq2, mwe2, ddone2, maddr2, st2);
    end
    dreq = 1'b0; dwe = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      vec_cnt++;
      if (ddone2 !== 1'b0 || mreq2 !== 1'b0 || st2 !== S_IDLE) begin
        err_cnt++;
        $display("FAIL reset_quiet: got ddone=%b mreq=%b st=%0d required 0 0 0", ddone2, mreq2, st2);
      end
    end
  endtask

  task automatic test_fetch();
    do_reset();
    step();  // cycle 0
    ireq = 1'b1; iaddr = 32'h40;
    exp_q.push_back(32'h8C220004);
    sample();
    vec_cnt++;
    if (istall2 !== 1'b1 || mreq2 !== 1'b0) begin
      err_cnt++; $display("FAIL fetch_c0: got istall=%b mreq=%b required 1 0", istall2, mreq2);
    end
    step();  // cycle 1
    sample();
    vec_cnt++;
    if (mreq2 !== 1'b1 || maddr2 !== 32'h40 || mwe2 !== 1'b0 || istall2 !== 1'b1) begin
      err_cnt++;
      $display("FAIL fetch_issue: got mreq=%b maddr=%h mwe=%b istall=%b required 1 00000040 0 1",
               mreq2, maddr2, mwe2, istall2);
    end
    step();  // cycle 2
    mrdata = 32'h8C220004;
    sample();
    vec_cnt++;
    if (mreq2 !== 1'b0 || istall2 !== 1'b1 || idone2 !== 1'b0) begin
      err_cnt++;
      $display("FAIL fetch_c2: got mreq=%b istall=%b idone=%b required 0 1 0", mreq2, istall2, idone2);
    end
    step();  // cycle 3
    mrdata = 32'h0;
    sample();
    pop_exp(exp_v);
    vec_cnt++;
    if (idone2 !== 1'b1 || irdata2 !== exp_v || istall2 !== 1'b0) begin
      err_cnt++;
      $display("FAIL fetch_done: got idone=%b irdata=%h istall=%b required 1 %h 0",
               idone2, irdata2, istall2, exp_v);
    end
    step();  // cycle 4
    ireq = 1'b0;
    sample();
    vec_cnt++;
    if (idone2 !== 1'b0 || st2 !== S_IDLE || irdata2 !== 32'h8C220004) begin
      err_cnt++;
      $display("FAIL fetch_after: got idone=%b st=%0d irdata=%h required 0 0 8c220004",
               idone2, st2, irdata2);
    end
  endtask

  task automatic test_store();
    do_reset();
    step();  // cycle 0
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h100; dwdata = 32'hDEADBEEF;
    sample();
    vec_cnt++;
    if (dstall2 !== 1'b1) begin
      err_cnt++; $display("FAIL store_stall: got %b required 1", dstall2);
    end
    step();  // cycle 1
    sample();
    vec_cnt++;
    if (mreq2 !== 1'b1 || mwe2 !== 1'b1 || maddr2 !== 32'h100 || mwdata2 !== 32'hDEADBEEF) begin
      err_cnt++;
      $display("FAIL store_issue: got mreq=%b mwe=%b maddr=%h mwdata=%h required 1 1 00000100 deadbeef",
               mreq2, mwe2, maddr2, mwdata2);
    end
    step();  // cycle 2
    sample();
    vec_cnt++;
    if (mwe2 !== 1'b0 || mreq2 !== 1'b0 || mwdata2 !== 32'hDEADBEEF || maddr2 !== 32'h100) begin
      err_cnt++;
      $display("FAIL store_hold: got mwe=%b mreq=%b mwdata=%h maddr=%h required 0 0 deadbeef 00000100",
               mwe2, mreq2, mwdata2, maddr2);
    end
    step();  // cycle 3
    sample();
    vec_cnt++;
    if (ddone2 !== 1'b1 || dstall2 !== 1'b0 || idone2 !== 1'b0) begin
      err_cnt++;
      $display("FAIL store_done: got ddone=%b dstall=%b idone=%b required 1 0 0", ddone2, dstall2, idone2);
    end
    step();
    dreq = 1'b0; dwe = 1'b0;
  endtask

  task automatic test_load_lat1();
    do_reset();
    step();  // cycle 0
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h20;
    exp_q.push_back(32'h12345678);
    step();  // cycle 1
    mrdata = 32'h12345678;
    sample();
    vec_cnt++;
    if (mreq1 !== 1'b1 || maddr1 !== 32'h20 || mwe1 !== 1'b0) begin
      err_cnt++;
      $display("FAIL lat1_issue: got mreq=%b maddr=%h mwe=%b required 1 00000020 0", mreq1, maddr1, mwe1);
    end
    step();  // cycle 2
    mrdata = 32'h0;
    sample();
    pop_exp(exp_v);
    vec_cnt++;
    if (ddone1 !== 1'b1 || drdata1 !== exp_v) begin
      err_cnt++; $display("FAIL lat1_done: got ddone=%b drdata=%h required 1 %h", ddone1, drdata1, exp_v);
    end
    step();
    dreq = 1'b0;
    sample();
    vec_cnt++;
    if (ddone1 !== 1'b0 || st1 !== S_IDLE) begin
      err_cnt++; $display("FAIL lat1_after: got ddone=%b st=%0d required 0 0", ddone1, st1);
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      step();
      case (c)
        0: begin
          ireq = 1'b1; dreq = 1'b1; dwe = 1'b0; iaddr = 32'h200; daddr = 32'h300;
          exp_q.push_back(32'hA5A50F0F);
          exp_q.push_back(32'h13572468);
        end
        2: mrdata = 32'hA5A50F0F;
        4: dreq = 1'b0;
        6: mrdata = 32'h13572468;
        8: ireq = 1'b0;
        default: mrdata = 32'h0;
      endcase
      sample();
      if (c <= 6) begin
        vec_cnt++;
        if (istall2 !== 1'b1) begin
          err_cnt++; $display("FAIL coll_istall_c%0d: got %b required 1", c, istall2);
        end
      end
      if (c == 1) begin
        vec_cnt++;
        if (mreq2 !== 1'b1 || maddr2 !== 32'h300) begin
          err_cnt++; $display("FAIL coll_dissue: got mreq=%b maddr=%h required 1 00000300", mreq2, maddr2);
        end
      end
      if (c == 3) begin
        pop_exp(exp_v);
        vec_cnt++;
        if (ddone2 !== 1'b1 || drdata2 !== exp_v || idone2 !== 1'b0) begin
          err_cnt++;
          $display("FAIL coll_ddone: got ddone=%b drdata=%h idone=%b required 1 %h 0",
                   ddone2, drdata2, idone2, exp_v);
        end
      end
      if (c == 4) begin
        vec_cnt++;
        if (mreq2 !== 1'b0 || st2 !== S_IDLE) begin
          err_cnt++; $display("FAIL coll_gap: got mreq=%b st=%0d required 0 0", mreq2, st2);
        end
      end
      if (c == 5) begin
        vec_cnt++;
        if (mreq2 !== 1'b1 || maddr2 !== 32'h200 || mwe2 !== 1'b0) begin
          err_cnt++;
          $display("FAIL coll_iissue: got mreq=%b maddr=%h mwe=%b required 1 00000200 0", mreq2, maddr2, mwe2);
        end
      end
      if (c == 7) begin
        pop_exp(exp_v);
        vec_cnt++;
        if (idone2 !== 1'b1 || irdata2 !== exp_v || istall2 !== 1'b0) begin
          err_cnt++;
          $display("FAIL coll_idone: got idone=%b irdata=%h istall=%b required 1 %h 0",
                   idone2, irdata2, istall2, exp_v);
        end
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      step();
      case (c)
        0: begin
          ireq = 1'b1; iaddr = 32'h80;
          exp_q.push_back(32'hCAFEF00D);
        end
        2: ireq = 1'b0;
        3: mrdata = 32'hCAFEF00D;
        default: mrdata = 32'h0;
      endcase
      sample();
      if (c == 1) begin
        vec_cnt++;
        if (mreq3 !== 1'b1 || maddr3 !== 32'h80) begin
          err_cnt++; $display("FAIL drop_issue: got mreq=%b maddr=%h required 1 00000080", mreq3, maddr3);
        end
      end
      if (c == 4) begin
        pop_exp(exp_v);
        vec_cnt++;
        if (idone3 !== 1'b1 || irdata3 !== exp_v) begin
          err_cnt++; $display("FAIL drop_done: got idone=%b irdata=%h required 1 %h", idone3, irdata3, exp_v);
        end
      end
      if (c >= 6) begin
        vec_cnt++;
        if (mreq3 !== 1'b0 || idone3 !== 1'b0 || st3 !== S_IDLE) begin
          err_cnt++;
          $display("FAIL drop_noreissue_c%0d: got mreq=%b idone=%b st=%0d required 0 0 0",
                   c, mreq3, idone3, st3);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        is_data;
    logic [31:0] addr, val;
    logic        seen;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      is_data = 1'($urandom_range(0, 1));
      addr = {$urandom_range(0, 32'hFFFF), 2'b00};
      val = $urandom();
      step();  // cycle 0 of this access; previous request is dropped here
      ireq = ~is_data; dreq = is_data; dwe = 1'b0;
      iaddr = addr; daddr = addr;
      exp_q.push_back(val);
      seen = 1'b0;
      for (int k = 1; k <= 8 && !seen; k++) begin
        step();
        mrdata = (k == 2) ? val : 32'h0;
        sample();
        if (k == 1) begin
          vec_cnt++;
          if (mreq2 !== 1'b1 || maddr2 !== addr) begin
            err_cnt++;
            $display("FAIL b2b_issue_%0d: got mreq=%b maddr=%h required 1 %h", t, mreq2, maddr2, addr);
          end
        end
        if ((is_data ? ddone2 : idone2) === 1'b1) begin
          seen = 1'b1;
          pop_exp(exp_v);
          vec_cnt++;
          if ((is_data ? drdata2 : irdata2) !== exp_v || k != 3) begin
            err_cnt++;
            $display("FAIL b2b_data_%0d: got data=%h at cycle %0d required %h at cycle 3",
                     t, is_data ? drdata2 : irdata2, k, exp_v);
          end
        end
      end
      if (!seen) begin
        vec_cnt++; err_cnt++;
        $display("FAIL b2b_timeout_%0d: got no done within 8 cycles, required done in cycle 3", t);
        void'(exp_q.pop_front());
      end
    end
    step();
    ireq = 1'b0; dreq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_load_lat1();
    test_collision();
    test_drop();
    test_back_to_back();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++; $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
